// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the generic pipeline stage register and its EX/MEM control packing.
package pipe_stage_reg_pkg;

    localparam int unsigned DEF_DATA_W   = 64;
    localparam int unsigned EXMEM_CTRL_W = 5;

    // EX/MEM control payload, packed at the instance into CTRL
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] mem_to_reg;
    } exmem_ctrl_t;

    localparam int unsigned EXMEM_MEM_READ_BIT  = 4;
    localparam int unsigned EXMEM_MEM_WRITE_BIT = 3;
    localparam int unsigned EXMEM_REG_WRITE_BIT = 2;
    localparam int unsigned EXMEM_MEM_TO_REG_LO = 0;

    localparam exmem_ctrl_t EXMEM_CTRL_NOP = '0;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid + data + ctrl with load, clear-to-NOP and hold.
module pipe_slot #(
    parameter int unsigned       DATA_W   = 64,
    parameter int unsigned       CTRL_W   = 5,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    // Clear wins over load; data is left stale on clear since it is don't-care for a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= CTRL_NOP;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= CTRL_NOP;
        end else if (load) begin
            valid <= 1'b1;
            data  <= d_data;
            ctrl  <= d_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline register with flush, bubble masking and optional skid entry.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned       DATA_W   = DEF_DATA_W,
    parameter int unsigned       CTRL_W   = EXMEM_CTRL_W,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
    parameter bit                SKID     = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o
);

    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] m_ctrl;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic [CTRL_W-1:0] s_ctrl;

    logic              accept;
    logic              consume;
    logic              m_load;
    logic              m_clear;
    logic              m_from_s;
    logic [DATA_W-1:0] m_d_data;
    logic [CTRL_W-1:0] m_d_ctrl;

    assign accept   = in_valid_i & in_ready_o;
    assign consume  = m_valid & out_ready_i;
    assign m_d_data = m_from_s ? s_data : in_data_i;
    assign m_d_ctrl = m_from_s ? s_ctrl : in_ctrl_i;

    pipe_slot #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CTRL_NOP (CTRL_NOP)
    ) u_m (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (m_load),
        .clear  (m_clear),
        .d_data (m_d_data),
        .d_ctrl (m_d_ctrl),
        .valid  (m_valid),
        .data   (m_data),
        .ctrl   (m_ctrl)
    );

    generate
        if (SKID) begin : g_skid
            logic s_load;
            logic s_clear;

            pipe_slot #(
                .DATA_W   (DATA_W),
                .CTRL_W   (CTRL_W),
                .CTRL_NOP (CTRL_NOP)
            ) u_s (
                .clk    (clk),
                .rst_n  (rst_n),
                .load   (s_load),
                .clear  (s_clear),
                .d_data (in_data_i),
                .d_ctrl (in_ctrl_i),
                .valid  (s_valid),
                .data   (s_data),
                .ctrl   (s_ctrl)
            );

            // Ready comes straight from the skid flop, so no path from out_ready_i
            assign in_ready_o = ~s_valid;

            // Skid drains into M before any new input; S only fills while M stalls
            always_comb begin
                m_load   = 1'b0;
                m_clear  = 1'b0;
                m_from_s = 1'b0;
                s_load   = 1'b0;
                s_clear  = 1'b0;
                if (flush_i) begin
                    m_clear = 1'b1;
                    s_clear = 1'b1;
                end else if (!m_valid || consume) begin
                    if (s_valid) begin
                        m_load   = 1'b1;
                        m_from_s = 1'b1;
                        s_clear  = 1'b1;
                    end else if (accept) begin
                        m_load = 1'b1;
                    end else begin
                        m_clear = 1'b1;
                    end
                end else if (accept) begin
                    s_load = 1'b1;
                end
            end
        end else begin : g_single
            assign s_valid    = 1'b0;
            assign s_data     = '0;
            assign s_ctrl     = CTRL_NOP;
            assign in_ready_o = ~m_valid | out_ready_i;

            always_comb begin
                m_load   = 1'b0;
                m_clear  = 1'b0;
                m_from_s = 1'b0;
                if (flush_i) begin
                    m_clear = 1'b1;
                end else if (accept) begin
                    m_load = 1'b1;
                end else if (consume) begin
                    m_clear = 1'b1;
                end
            end
        end
    endgenerate

    assign out_valid_o = m_valid;
    assign out_data_o  = m_data;
    assign out_ctrl_o  = m_ctrl;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg in skid and single-entry configurations.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 64;
    localparam int unsigned CW = 5;
    localparam logic [CW-1:0] NOP1 = 5'h00;
    localparam logic [CW-1:0] NOP0 = 5'h0A;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } item_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          out_ready = 1'b0;

    logic          ir1, ov1, ir0, ov0;
    logic [DW-1:0] od1, od0;
    logic [CW-1:0] oc1, oc0;

    item_t q1[$];
    item_t q0[$];
    item_t tmp;
    bit    mrdy1 = 1'b1;
    bit    mrdy0 = 1'b1;
    int    tests = 0;
    int    fails = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(NOP1), .SKID(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir1),
        .in_data_i(in_data), .in_ctrl_i(in_ctrl), .out_valid_o(ov1), .out_ready_i(out_ready),
        .out_data_o(od1), .out_ctrl_o(oc1)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(NOP0), .SKID(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir0),
        .in_data_i(in_data), .in_ctrl_i(in_ctrl), .out_valid_o(ov0), .out_ready_i(out_ready),
        .out_data_o(od0), .out_ctrl_o(oc0)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] rand_ctrl();
        logic [CW-1:0] c;
        c = CW'($urandom_range(1, 31));
        if (c == NOP0) c = c + CW'(1);
        return c;
    endfunction

    // Monitor: model holds items in flight; head must be on the outputs
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            mrdy1 = q1.size() < 2;
            chk("ready_skid", 64'(ir1), 64'(mrdy1));
            chk("valid_skid", 64'(ov1), 64'(q1.size() != 0));
            if (q1.size() != 0) begin
                chk("data_skid", od1, q1[0].d);
                chk("ctrl_skid", 64'(oc1), 64'(q1[0].c));
            end else begin
                chk("bubble_ctrl_skid", 64'(oc1), 64'(NOP1));
            end
            if (flush) q1.delete();
            else if (q1.size() != 0 && out_ready) tmp = q1.pop_front();

            mrdy0 = (q0.size() == 0) || out_ready;
            chk("ready_single", 64'(ir0), 64'(mrdy0));
            chk("valid_single", 64'(ov0), 64'(q0.size() != 0));
            if (q0.size() != 0) begin
                chk("data_single", od0, q0[0].d);
                chk("ctrl_single", 64'(oc0), 64'(q0[0].c));
            end else begin
                chk("bubble_ctrl_single", 64'(oc0), 64'(NOP0));
            end
            if (flush) q0.delete();
            else if (q0.size() != 0 && out_ready) tmp = q0.pop_front();
        end
    end

    // Drive one cycle; accepted items are pushed as expected output
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic ordy, input logic fl);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        #2;
        if (rst_n && v && !fl) begin
            if (mrdy1) q1.push_back('{d: d, c: c});
            if (mrdy0) q0.push_back('{d: d, c: c});
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, ordy, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2, 1'b1);

        // Streaming 1..8 back to back
        for (int i = 1; i <= 8; i++) drive(1'b1, DW'(i), CW'(i), 1'b1, 1'b0);
        idle(3, 1'b1);

        // Skid stall: A then B with stall, hold, release
        drive(1'b1, 64'hAAAA, 5'h01, 1'b1, 1'b0);
        drive(1'b1, 64'hBBBB, 5'h02, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(3, 1'b1);

        // Flush with M and S full and C offered
        drive(1'b1, 64'hA1, 5'h03, 1'b1, 1'b0);
        drive(1'b1, 64'hB1, 5'h04, 1'b0, 1'b0);
        drive(1'b1, 64'hC1, 5'h05, 1'b0, 1'b1);
        idle(3, 1'b1);

        // Single-entry back-pressure: ready follows out_ready in the same cycle
        drive(1'b1, 64'h55, 5'h06, 1'b1, 1'b0);
        idle(2, 1'b0);
        idle(2, 1'b1);

        // Reset in the middle of a skid stall
        drive(1'b1, 64'hD1, 5'h07, 1'b1, 1'b0);
        drive(1'b1, 64'hD2, 5'h08, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_valid_skid", 64'(ov1), 64'(0));
        chk("rst_ctrl_skid", 64'(oc1), 64'(NOP1));
        chk("rst_data_skid", od1, 64'(0));
        chk("rst_ready_skid", 64'(ir1), 64'(1));
        chk("rst_valid_single", 64'(ov0), 64'(0));
        chk("rst_ctrl_single", 64'(oc0), 64'(NOP0));
        chk("rst_data_single", od0, 64'(0));
        chk("rst_ready_single", 64'(ir0), 64'(1));
        q1.delete();
        q0.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(2, 1'b1);

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            drive(($urandom % 4) != 0, {$urandom(), $urandom()}, rand_ctrl(),
                  ($urandom % 4) != 0, ($urandom % 32) == 0);
        end
        idle(4, 1'b1);
        chk("drained_skid", 64'(q1.size()), 64'(0));
        chk("drained_single", 64'(q0.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
